// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and helpers for the counter button controller
package counter_ctrl_pkg;

    typedef enum logic [1:0] {NONE, UP, DN, CLR} press_code_t;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} btn_state_t;

    function automatic int CeilLog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/counter_button_ctrl.sv
// rtl/counter_button_ctrl.sv - debounces up/down/clear buttons into counter step strobes
module counter_button_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = 50000,
    parameter bit REPEAT_EN            = 1'b1,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic btn_clr,
    output logic enb_o,
    output logic op_o,
    output logic sync_rst_enb_o,
    output logic held_o
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int MAX_CYC = (MAX_AB > REPEAT_PERIOD_CYCLES) ? MAX_AB : REPEAT_PERIOD_CYCLES;
    localparam int TMR_W   = CeilLog2(MAX_CYC) + 1;

    localparam logic [TMR_W-1:0] DB_LAST    = TMR_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] PER_LAST   = TMR_W'(REPEAT_PERIOD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

    logic [2:0]       btn_sync;
    press_code_t      code;
    press_code_t      latched;
    btn_state_t       state;
    logic [TMR_W-1:0] db_tmr;
    logic [TMR_W-1:0] rep_tmr;
    logic             rep_first;
    logic [TMR_W-1:0] rep_last;
    logic             rep_active;

    sync_2ff #(.W(3)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({btn_clr, btn_dn, btn_up}),
        .q   (btn_sync)
    );

    // Clear wins outright; up and down together cancel each other.
    always_comb begin
        code = NONE;
        if (btn_sync[2]) begin
            code = CLR;
        end else if (btn_sync[0] && !btn_sync[1]) begin
            code = UP;
        end else if (btn_sync[1] && !btn_sync[0]) begin
            code = DN;
        end
    end

    assign rep_last   = rep_first ? DELAY_LAST : PER_LAST;
    assign rep_active = REPEAT_EN && ((latched == UP) || (latched == DN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            latched        <= NONE;
            db_tmr         <= '0;
            rep_tmr        <= '0;
            rep_first      <= 1'b1;
            enb_o          <= 1'b0;
            op_o           <= 1'b1;
            sync_rst_enb_o <= 1'b0;
            held_o         <= 1'b0;
        end else begin
            enb_o          <= 1'b0;
            sync_rst_enb_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (code != NONE) begin
                        state   <= PRESS_DB;
                        latched <= code;
                        db_tmr  <= '0;
                    end
                end
                PRESS_DB: begin
                    if (code != latched) begin
                        state <= IDLE;
                    end else if (db_tmr == DB_LAST) begin
                        state     <= HELD;
                        held_o    <= 1'b1;
                        enb_o     <= 1'b1;
                        rep_tmr   <= '0;
                        rep_first <= 1'b1;
                        if (latched == CLR) begin
                            sync_rst_enb_o <= 1'b1;
                        end else begin
                            op_o <= (latched == UP);
                        end
                    end else begin
                        db_tmr <= db_tmr + TMR_ONE;
                    end
                end
                HELD: begin
                    if (code != latched) begin
                        state  <= REL_DB;
                        db_tmr <= '0;
                    end else if (rep_active) begin
                        // A due repeat waits one cycle if it would abut the previous strobe.
                        if (rep_tmr == rep_last) begin
                            if (!enb_o) begin
                                enb_o     <= 1'b1;
                                rep_tmr   <= '0;
                                rep_first <= 1'b0;
                            end
                        end else begin
                            rep_tmr <= rep_tmr + TMR_ONE;
                        end
                    end
                end
                REL_DB: begin
                    if (code == latched) begin
                        state     <= HELD;
                        rep_tmr   <= '0;
                        rep_first <= 1'b1;
                    end else if (db_tmr == DB_LAST) begin
                        state  <= IDLE;
                        held_o <= 1'b0;
                    end else begin
                        db_tmr <= db_tmr + TMR_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_button_ctrl.sv
// tb/tb_counter_button_ctrl.sv - scoreboard bench for counter_button_ctrl
module tb_counter_button_ctrl;

    localparam int DB   = 4;
    localparam int DLY  = 10;
    localparam int PER  = 3;
    localparam int HOLD = 29;

    typedef struct {
        int cyc;
        bit op;
        bit clr;
    } strobe_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic btn_clr = 1'b0;
    logic enb0, op0, clr0, held0;
    logic enb1, op1, clr1, held1;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int n_str0 = 0;
    int n_str1 = 0;
    bit prev0 = 1'b0;
    bit prev1 = 1'b0;
    strobe_t sb0[$];
    strobe_t sb1[$];

    // Instance 0 auto-repeats, instance 1 gives one step per press; both see the same buttons.
    counter_button_ctrl #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1),
        .REPEAT_DELAY_CYCLES(DLY), .REPEAT_PERIOD_CYCLES(PER)
    ) dut_rep (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
        .enb_o(enb0), .op_o(op0), .sync_rst_enb_o(clr0), .held_o(held0)
    );

    counter_button_ctrl #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0),
        .REPEAT_DELAY_CYCLES(DLY), .REPEAT_PERIOD_CYCLES(PER)
    ) dut_norep (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
        .enb_o(enb1), .op_o(op1), .sync_rst_enb_o(clr1), .held_o(held1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_both(input int c, input bit op, input bit clr);
        strobe_t s;
        s.cyc = c;
        s.op  = op;
        s.clr = clr;
        sb0.push_back(s);
        sb1.push_back(s);
    endtask

    task automatic push_rep(input int c, input bit op);
        strobe_t s;
        s.cyc = c;
        s.op  = op;
        s.clr = 1'b0;
        sb0.push_back(s);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_sb_rep"}, sb0.size(), 0);
        check({tag, "_sb_norep"}, sb1.size(), 0);
    endtask

    always @(negedge clk) begin : monitor
        strobe_t s;
        if (enb0) begin
            n_str0++;
            check("gap_rep", prev0, 0);
            if (sb0.size() == 0) begin
                check("extra_strobe_rep", 1, 0);
            end else begin
                s = sb0.pop_front();
                check("cyc_rep", cyc, s.cyc);
                check("op_rep", op0, s.op);
                check("clr_rep", clr0, s.clr);
            end
        end else if (clr0) begin
            check("clr_alone_rep", 1, 0);
        end
        prev0 = enb0;
        if (enb1) begin
            n_str1++;
            check("gap_norep", prev1, 0);
            if (sb1.size() == 0) begin
                check("extra_strobe_norep", 1, 0);
            end else begin
                s = sb1.pop_front();
                check("cyc_norep", cyc, s.cyc);
                check("op_norep", op1, s.op);
                check("clr_norep", clr1, s.clr);
            end
        end else if (clr1) begin
            check("clr_alone_norep", 1, 0);
        end
        prev1 = enb1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int t0;
        int s0;
        int s1;

        idle(2);
        check("rst_enb", {enb0, enb1}, 2'b00);
        check("rst_clr", {clr0, clr1}, 2'b00);
        check("rst_held", {held0, held1}, 2'b00);
        check("rst_op", {op0, op1}, 2'b11);
        rst = 1'b1;
        idle(3);

        // Clean up press, single step, release debounce.
        btn_up = 1'b1;
        t0 = cyc + 1;
        push_both(t0 + DB + 2, 1'b1, 1'b0);
        idle(6);
        btn_up = 1'b0;
        idle(6);
        check("up_held_rel_db", {held0, held1}, 2'b11);
        idle(1);
        check("up_held_idle", {held0, held1}, 2'b00);
        idle(4);
        check_drained("up");

        // Long up hold: acceptance, first repeat after DLY, then every PER.
        s0 = n_str0;
        s1 = n_str1;
        btn_up = 1'b1;
        t0 = cyc + 1;
        push_both(t0 + DB + 2, 1'b1, 1'b0);
        for (int e = t0 + DB + 2 + DLY; e <= t0 + HOLD + 1; e += PER) push_rep(e, 1'b1);
        idle(HOLD);
        btn_up = 1'b0;
        idle(14);
        check("rep_count", n_str0 - s0, 2 + (HOLD + 1 - (DB + 2) - DLY) / PER);
        check("norep_count", n_str1 - s1, 1);
        check("rep_op", {op0, op1}, 2'b11);
        check_drained("repeat");

        // Clear while up is held is ignored; a fresh clear then steps once.
        btn_up = 1'b1;
        t0 = cyc + 1;
        push_both(t0 + DB + 2, 1'b1, 1'b0);
        idle(8);
        btn_clr = 1'b1;
        idle(3);
        btn_up = 1'b0;
        btn_clr = 1'b0;
        idle(3);
        check("clr_rel_db_held", {held0, held1}, 2'b11);
        idle(1);
        check("clr_rel_db_idle", {held0, held1}, 2'b00);
        idle(3);
        btn_clr = 1'b1;
        t0 = cyc + 1;
        push_both(t0 + DB + 2, 1'b1, 1'b1);
        idle(20);
        btn_clr = 1'b0;
        idle(12);
        check_drained("clear");

        // Up and down together never leave IDLE.
        btn_up = 1'b1;
        btn_dn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            check("both_held", {held0, held1}, 2'b00);
        end
        btn_up = 1'b0;
        btn_dn = 1'b0;
        idle(4);
        check_drained("both");

        // Bouncing down press: only the final stable level is accepted.
        for (int i = 0; i < 3; i++) begin
            btn_dn = 1'b1;
            idle(2);
            btn_dn = 1'b0;
            idle(2);
        end
        btn_dn = 1'b1;
        t0 = cyc + 1;
        push_both(t0 + DB + 2, 1'b0, 1'b0);
        idle(8);
        btn_dn = 1'b0;
        idle(12);
        check("dn_op", {op0, op1}, 2'b00);
        check_drained("bounce");

        // Reset in the middle of the press debounce, button kept held.
        btn_dn = 1'b1;
        idle(5);
        rst = 1'b0;
        #1;
        check("midrst_enb", {enb0, enb1}, 2'b00);
        check("midrst_clr", {clr0, clr1}, 2'b00);
        check("midrst_held", {held0, held1}, 2'b00);
        check("midrst_op", {op0, op1}, 2'b11);
        idle(2);
        rst = 1'b1;
        t0 = cyc + 1;
        push_both(t0 + DB + 2, 1'b0, 1'b0);
        idle(8);
        btn_dn = 1'b0;
        idle(12);
        check_drained("midrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
